// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one combinational ALU between requesters
package alufnt;
  typedef enum logic [3:0] {
    add    = 4'd0,
    sl     = 4'd1,
    seq    = 4'd2,
    sne    = 4'd3,
    xor_op = 4'd4,
    sr     = 4'd5,
    or_op  = 4'd6,
    and_op = 4'd7,
    sub    = 4'd10,
    sra    = 4'd11,
    slt    = 4'd12,
    sge    = 4'd13,
    sltu   = 4'd14,
    sgeu   = 4'd15
  } alu_func_t;
endpackage

module alu_share_arb #(
  parameter int NUM_REQ = 2,
  parameter int FNW     = 4,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*FNW-1:0] req_fn,
  input  logic [NUM_REQ*32-1:0]  req_in1,
  input  logic [NUM_REQ*32-1:0]  req_in2,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [FNW-1:0]         alu_fn,
  output logic [31:0]            alu_in1,
  output logic [31:0]            alu_in2,
  input  logic [31:0]            alu_out,
  input  logic [31:0]            alu_cmp_out,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_data,
  output logic                   resp_cmp,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy
);

  logic           full_q, full_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]    data_q, data_d;
  logic           cmp_q, cmp_d;
  logic [IDW-1:0] id_q, id_d;

  logic           slot_free, gnt_found, do_grant;
  logic [IDW-1:0] gnt_idx, cand_idx;
  logic           unused_cmp_hi;

  assign unused_cmp_hi = ^alu_cmp_out[31:1];

  // The slot can take a new result if empty or being drained by its owner this cycle.
  assign slot_free = !full_q || resp_ready[id_q];
  assign do_grant  = gnt_found && slot_free && !rst;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_fn    = FNW'(alufnt::add);
    alu_in1   = '0;
    alu_in2   = '0;
    if (do_grant) begin
      req_ready[gnt_idx] = 1'b1;
      alu_fn             = req_fn[gnt_idx*FNW +: FNW];
      alu_in1            = req_in1[gnt_idx*32 +: 32];
      alu_in2            = req_in2[gnt_idx*32 +: 32];
    end
  end

  always_comb begin
    full_d   = full_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    cmp_d    = cmp_q;
    id_d     = id_q;
    if (do_grant) begin
      full_d   = 1'b1;
      data_d   = alu_out;
      cmp_d    = alu_cmp_out[0];
      id_d     = gnt_idx;
      rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (full_q && resp_ready[id_q]) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 1'b0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      cmp_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      cmp_q    <= cmp_d;
      id_q     <= id_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = full_q && !rst && (id_q == IDW'(i));
    end
  end

  assign resp_data = data_q;
  assign resp_cmp  = cmp_q;
  assign resp_id   = id_q;
  assign busy      = full_q && !rst;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed table-driven bench for alu_share_arb
module tb_alu_share_arb;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SL  = 4'd1;
  localparam logic [3:0] F_SUB = 4'd10;
  localparam logic [3:0] F_SLT = 4'd12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // two-requester instance
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_fn;
  logic [63:0] req_in1, req_in2;
  logic [3:0]  alu_fn;
  logic [31:0] alu_in1, alu_in2, alu_out, alu_cmp_out, resp_data;
  logic        resp_cmp, busy, cmp_bit;
  logic [0:0]  resp_id;

  // three-requester instance
  logic [2:0]  rv3, rdy3, rvalid3, rready3;
  logic [11:0] fn3;
  logic [95:0] a3, b3;
  logic [3:0]  afn3;
  logic [31:0] ain1_3, ain2_3, aout3, acmp3, rdata3;
  logic        rcmp3, busy3, cmp_bit3;
  logic [1:0]  rid3;

  function automatic logic [32:0] alu_model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    logic        c;
    c = 1'b0;
    case (fn)
      F_ADD:   o = a + b;
      F_SL:    o = a << b[4:0];
      F_SUB:   o = a - b;
      F_SLT: begin
        c = $signed(a) < $signed(b);
        o = {31'b0, c};
      end
      default: o = a ^ b;
    endcase
    return {c, o};
  endfunction

  assign {cmp_bit, alu_out}   = alu_model(alu_fn, alu_in1, alu_in2);
  assign alu_cmp_out          = {31'h2AAA_AAAA, cmp_bit};
  assign {cmp_bit3, aout3}    = alu_model(afn3, ain1_3, ain2_3);
  assign acmp3                = {31'h7FFF_FFFF, cmp_bit3};

  alu_share_arb #(.NUM_REQ(2), .FNW(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_fn(req_fn),
    .req_in1(req_in1), .req_in2(req_in2), .req_ready(req_ready),
    .alu_fn(alu_fn), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_cmp_out(alu_cmp_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_cmp(resp_cmp), .resp_id(resp_id), .busy(busy)
  );

  alu_share_arb #(.NUM_REQ(3), .FNW(4)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_fn(fn3),
    .req_in1(a3), .req_in2(b3), .req_ready(rdy3),
    .alu_fn(afn3), .alu_in1(ain1_3), .alu_in2(ain2_3),
    .alu_out(aout3), .alu_cmp_out(acmp3),
    .resp_valid(rvalid3), .resp_ready(rready3), .resp_data(rdata3),
    .resp_cmp(rcmp3), .resp_id(rid3), .busy(busy3)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [3:0]  fn0;
    logic [31:0] a0, b0;
    logic [3:0]  fn1;
    logic [31:0] a1, b1;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic [3:0]  e_fn;
    logic [31:0] e_a, e_b;
    logic [1:0]  e_rv;
    logic [31:0] e_d;
    logic        e_c;
    logic        e_id;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt[3];
    int since[3];
    int grants, cyc, idx, exp_ptr;

    // single op, idle, round-robin, back-pressure, reset mid-op
    tbl.push_back('{1'b0, 2'b01, F_ADD, 32'd5, 32'hFFFF_FFFF, F_ADD, 32'd0, 32'd0, 2'b01, 2'b01, F_ADD, 32'd5, 32'hFFFF_FFFF, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b01, 2'b00, F_ADD, 32'd0, 32'd0, 2'b01, 32'd4, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b00, 2'b00, F_ADD, 32'd0, 32'd0, 2'b00, 32'd4, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, F_SUB, 32'd10, 32'd3, F_SL, 32'd1, 32'd4, 2'b11, 2'b10, F_SL, 32'd1, 32'd4, 2'b00, 32'd4, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, F_SUB, 32'd10, 32'd3, F_SL, 32'd1, 32'd4, 2'b11, 2'b01, F_SUB, 32'd10, 32'd3, 2'b10, 32'h10, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 2'b11, F_SUB, 32'd10, 32'd3, F_SL, 32'd1, 32'd4, 2'b11, 2'b10, F_SL, 32'd1, 32'd4, 2'b01, 32'h7, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b11, F_SUB, 32'd10, 32'd3, F_SL, 32'd1, 32'd4, 2'b11, 2'b01, F_SUB, 32'd10, 32'd3, 2'b10, 32'h10, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 2'b10, F_ADD, 32'd0, 32'd0, F_SLT, 32'hFFFF_FFFF, 32'd1, 2'b01, 2'b10, F_SLT, 32'hFFFF_FFFF, 32'd1, 2'b01, 32'h7, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 2'b01, F_ADD, 32'h100, 32'h23, F_SLT, 32'hFFFF_FFFF, 32'd1, 2'b01, 2'b00, F_ADD, 32'd0, 32'd0, 2'b10, 32'd1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 2'b01, F_ADD, 32'h100, 32'h23, F_SLT, 32'hFFFF_FFFF, 32'd1, 2'b10, 2'b01, F_ADD, 32'h100, 32'h23, 2'b10, 32'd1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b01, 2'b00, F_ADD, 32'd0, 32'd0, 2'b01, 32'h123, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b00, 2'b00, F_ADD, 32'd0, 32'd0, 2'b00, 32'h123, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b10, F_ADD, 32'd0, 32'd0, F_ADD, 32'd2, 32'd3, 2'b00, 2'b10, F_ADD, 32'd2, 32'd3, 2'b00, 32'h123, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b11, F_ADD, 32'd7, 32'd7, F_ADD, 32'd2, 32'd3, 2'b00, 2'b00, F_ADD, 32'd0, 32'd0, 2'b00, 32'd5, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b00, 2'b00, F_ADD, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, F_ADD, 32'd1, 32'd1, F_ADD, 32'd2, 32'd2, 2'b11, 2'b01, F_ADD, 32'd1, 32'd1, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b11, 2'b00, F_ADD, 32'd0, 32'd0, 2'b01, 32'd2, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b00, F_ADD, 32'd0, 32'd0, F_ADD, 32'd0, 32'd0, 2'b00, 2'b00, F_ADD, 32'd0, 32'd0, 2'b00, 32'd2, 1'b0, 1'b0, 1'b0});

    rst = 1'b1;
    req_valid = '0; req_fn = '0; req_in1 = '0; req_in2 = '0; resp_ready = '0;
    rv3 = '0; fn3 = '0; a3 = '0; b3 = '0; rready3 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset resp_valid", {30'b0, resp_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_id", {31'b0, resp_id}, 32'd0);

    foreach (tbl[i]) begin
      rst        = tbl[i].rst;
      req_valid  = tbl[i].v;
      req_fn     = {tbl[i].fn1, tbl[i].fn0};
      req_in1    = {tbl[i].a1, tbl[i].a0};
      req_in2    = {tbl[i].b1, tbl[i].b0};
      resp_ready = tbl[i].rr;
      #1;
      chk($sformatf("v%0d req_ready", i), {30'b0, req_ready}, {30'b0, tbl[i].e_rdy});
      chk($sformatf("v%0d alu_fn", i), {28'b0, alu_fn}, {28'b0, tbl[i].e_fn});
      chk($sformatf("v%0d alu_in1", i), alu_in1, tbl[i].e_a);
      chk($sformatf("v%0d alu_in2", i), alu_in2, tbl[i].e_b);
      chk($sformatf("v%0d resp_valid", i), {30'b0, resp_valid}, {30'b0, tbl[i].e_rv});
      chk($sformatf("v%0d resp_data", i), resp_data, tbl[i].e_d);
      chk($sformatf("v%0d resp_cmp", i), {31'b0, resp_cmp}, {31'b0, tbl[i].e_c});
      chk($sformatf("v%0d resp_id", i), {31'b0, resp_id}, {31'b0, tbl[i].e_id});
      chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      tick();
    end
    rst = 1'b0;
    req_valid = '0;

    // three requesters always valid, random response back-pressure
    rv3 = 3'b111;
    for (int j = 0; j < 3; j++) begin
      fn3[j*4 +: 4]  = F_ADD;
      a3[j*32 +: 32] = 32'(100 + j);
      b3[j*32 +: 32] = 32'd0;
      cnt[j]   = 0;
      since[j] = 0;
    end
    grants = 0; cyc = 0; exp_ptr = 0;
    while (grants < 30 && cyc < 400) begin
      rready3 = 3'($urandom_range(0, 7));
      #1;
      if (rvalid3 != 3'b000)
        chk("s3 resp_data", rdata3, 32'(100 + int'(rid3)));
      if (rdy3 != 3'b000) begin
        chk("s3 onehot", {31'b0, $onehot(rdy3)}, 32'd1);
        idx = 0;
        for (int j = 0; j < 3; j++) if (rdy3[j]) idx = j;
        chk("s3 order", 32'(idx), 32'(exp_ptr));
        for (int j = 0; j < 3; j++) begin
          if (j == idx) begin
            chk($sformatf("s3 gap%0d", j), {31'b0, since[j] <= 2}, 32'd1);
            since[j] = 0;
          end else begin
            since[j]++;
          end
        end
        cnt[idx]++;
        grants++;
        exp_ptr = (idx + 1) % 3;
      end
      tick();
      cyc++;
    end
    chk("s3 grants", 32'(grants), 32'd30);
    for (int j = 0; j < 3; j++)
      chk($sformatf("s3 count%0d", j), {31'b0, cnt[j] >= 9 && cnt[j] <= 11}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates one shared `alu` instance between NUM_REQ requesters, for example the execute stage and a multi-cycle address/branch helper.
- Each requester uses a valid/ready request handshake. The arbiter drives the ALU combinationally from the winning requester.
- The ALU result is captured into a single output slot, tagged with the owner's index.
- The result is returned to that owner over a per-requester valid/ready response handshake. Round-robin fairness; sustained throughput is 1 op/cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); index width IDW = $clog2(NUM_REQ), minimum 1.
- FNW, 4, width of alufnt::alu_func_t.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  request valid, one bit per requester
- req_fn  input  NUM_REQ*FNW  ALU function per requester; slice i is [i*FNW +: FNW]
- req_in1  input  NUM_REQ*32  operand 1 per requester; slice i is [i*32 +: 32]
- req_in2  input  NUM_REQ*32  operand 2 per requester
- req_ready  output  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i]
- alu_fn  output  FNW  to the shared ALU
- alu_in1  output  32  to the shared ALU
- alu_in2  output  32  to the shared ALU
- alu_out  input  32  ALU result
- alu_cmp_out  input  32  ALU compare word; only bit 0 is used
- resp_valid  output  NUM_REQ  response valid for requester i
- resp_ready  input  NUM_REQ  requester i accepts its response
- resp_data  output  32  captured ALU result (shared bus)
- resp_cmp  output  1  captured alu_cmp_out[0]
- resp_id  output  IDW  owner index of the current response
- busy  output  1  output slot occupied

Behaviour:
- **Reset (synchronous, rst=1 at a clk edge):**
  - full=0, rr_ptr=0, resp_data=0, resp_cmp=0, resp_id=0.
  - resp_valid=0, busy=0, req_ready=0 during the reset cycle.
  - Any in-flight or held response is discarded.
  - Requesters must re-issue after reset; an op accepted in the reset cycle is dropped.
- **Slot free (combinational):** slot_free = !full || resp_ready[resp_id].
- **Grant (combinational):**
  - If slot_free and any req_valid is high, grant the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot of that index; all zero otherwise.
  - req_ready never depends on req_valid of non-granted requesters beyond the priority search.
  - A requester may see req_ready=1 only while its own req_valid=1.
- **ALU drive:**
  - With a grant: alu_fn/alu_in1/alu_in2 = the granted requester's slices.
  - With no grant: alu_fn=alufnt::add, alu_in1=0, alu_in2=0. This quiets the datapath.
- **Capture at clk edge on grant:**
  - full<=1, resp_data<=alu_out, resp_cmp<=alu_cmp_out[0], resp_id<=granted index.
  - rr_ptr <= (granted index + 1) mod NUM_REQ.
- **Consume without grant:** full<=0 when full && resp_ready[resp_id] and there is no new grant. resp_data, resp_cmp and resp_id hold their values.
- **Consume and grant in the same cycle:** the slot is reloaded; full stays 1. Back-to-back throughput is 1/cycle.
- **rr_ptr:** unchanged when there is no grant.
- **Outputs:**
  - resp_valid[i] = full && (resp_id == i).
  - resp_ready of non-owners is ignored.
  - busy = full.
- **Hold rule:** while resp_valid[i] && !resp_ready[i], resp_data, resp_cmp and resp_id are stable. No grant is issued, so all req_ready=0.
- **Latency:** a request accepted in cycle N has its response valid in cycle N+1.
- **Requester obligations:** req_fn/in1/in2 must be stable while req_valid=1 and not yet accepted. The arbiter does not register the operands; the ALU path is purely combinational.
- **Fairness:**
  - With all requesters continuously valid and resp_ready held high, grants rotate 0,1,...,NUM_REQ-1,0...
  - No requester waits more than NUM_REQ-1 grants.
- **Idle:** with no valid requests the slot drains; busy falls the cycle after the final consume.
- **Illegal req_fn encodings:** passed through unchanged; the arbiter does not check them.

Test Plan:
- **Reset mid-operation:** full=1, resp_id=1, resp_ready=0, then rst=1 for 1 cycle -> next cycle resp_valid=00, busy=0, rr_ptr=0, resp_data=0.
- **Single op:** req0 valid, fn=add, in1=0x0000_0005, in2=0xFFFF_FFFF, resp_ready0=1 -> req_ready=01 in cycle N; cycle N+1 resp_valid=01, resp_data=0x0000_0004, resp_id=0; busy=0 at N+2.
- **Round-robin:** both valid every cycle, resp_ready=11, req0 ops sub 10-3, req1 ops sl 1<<4 -> grants 01,10,01,10; responses alternate 0x7 (id0), 0x10 (id1).
- **Back-pressure:** req1 slt in1=0xFFFF_FFFF, in2=1 accepted, resp_ready1=0 for 3 cycles, req0 valid throughout -> resp_data=1, resp_cmp=1, stable for 3 cycles, req_ready=00. Then resp_ready1=1 -> req0 is granted in that same cycle and its response is valid the next cycle.
- **Idle drive:** no req_valid -> alu_fn=add, alu_in1=alu_in2=0, req_ready=00; rr_ptr is unchanged. Verify with a following request from req1 when rr_ptr=1: req1 is granted over req0.
- **Starvation check:** NUM_REQ=3, all valid for 30 cycles with random resp_ready -> each requester receives 10±1 grants, and no gap exceeds 2 intervening grants.
